// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: write-to-o_tx_dv is 2 edges on an idle link, one byte per UART frame + 3 cycles.
// Backpressure: writes while full are dropped with a one-cycle o_overflow; launches wait on i_tx_active/i_tx_done.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_accept;
    logic              pop;

    assign o_count   = count;
    assign o_full    = (count == FULL_CNT);
    assign o_empty   = (count == '0);
    assign wr_accept = i_wr_en && !o_full;
    // Head is read from registered storage only, so a fresh write needs one edge before it can pop.
    assign pop       = (state == S_IDLE) && !o_empty && !i_tx_active;

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= i_wr_en && o_full;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= 8'h00;
        end else begin
            state   <= state_nxt;
            o_tx_dv <= pop;
            if (pop) begin
                o_tx_byte <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (pop) state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (i_tx_done) state_nxt = S_GAP;
            // uart_tx ignores a request during its done cycle; one idle cycle keeps us clear of it.
            S_GAP:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo driving a behavioural uart_tx (4 clocks/bit) and an 8N1 serial decoder.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_wr_en = 1'b0;
    logic [7:0]        i_wr_data = 8'h00;
    logic              o_full, o_empty, o_overflow, o_tx_dv;
    logic [ADDR_W:0]   o_count;
    logic [7:0]        o_tx_byte;

    logic       m_active, m_done, m_serial, m_busy;
    logic [9:0] m_sh;
    int         m_cnt, m_bit;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .i_tx_active (m_active),
        .i_tx_done   (m_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Transmitter model: start, 8 data LSB first, stop; done pulses one cycle, requests ignored then.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_active <= 1'b0; m_done <= 1'b0; m_serial <= 1'b1; m_busy <= 1'b0;
            m_sh <= '0; m_cnt <= 0; m_bit <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (o_tx_dv && !m_done) begin
                    m_busy <= 1'b1; m_active <= 1'b1; m_sh <= {1'b1, o_tx_byte, 1'b0};
                    m_cnt <= 0; m_bit <= 0; m_serial <= 1'b0;
                end
            end else if (m_cnt == 3) begin
                m_cnt <= 0;
                if (m_bit == 9) begin
                    m_busy <= 1'b0; m_active <= 1'b0; m_done <= 1'b1; m_serial <= 1'b1;
                end else begin
                    m_bit <= m_bit + 1;
                    m_serial <= m_sh[m_bit + 1];
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    logic [7:0] rx_q[$];
    logic       rx_busy;
    int         rx_cnt;
    logic [7:0] rx_sh;

    always @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_busy <= 1'b0; rx_cnt <= 0; rx_sh <= 8'h00;
        end else if (!rx_busy) begin
            if (m_serial == 1'b0) begin
                rx_busy <= 1'b1; rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh <= {m_serial, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
            end
        end
    end

    // Running event counters; tests compare deltas across their own window.
    logic prev_dv = 1'b0;
    int   n_dv = 0, n_long = 0, n_gapv = 0, n_unst = 0, n_ovf = 0, last_done = -100;

    always @(negedge i_clk) begin
        prev_dv <= o_tx_dv;
        if (o_tx_dv && !prev_dv) begin
            n_dv <= n_dv + 1;
            if (cyc - last_done < 2) n_gapv <= n_gapv + 1;
        end
        if (o_tx_dv && prev_dv) n_long <= n_long + 1;
        if (m_done) last_done <= cyc;
        if (m_active && o_tx_byte !== m_sh[8:1]) n_unst <= n_unst + 1;
        if (o_overflow) n_ovf <= n_ovf + 1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick();
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && !(o_empty && !m_active && !o_tx_dv && !rx_busy); i++) tick();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (5) begin
            i_wr_en   = 1'($urandom_range(0, 1));
            i_wr_data = 8'($urandom);
            tick();
        end
        checks++; if (o_tx_dv !== 1'b0)     begin errors++; $display("FAIL reset_dv: got %b want 0", o_tx_dv); end
        checks++; if (o_tx_byte !== 8'h00)  begin errors++; $display("FAIL reset_byte: got %h want 00", o_tx_byte); end
        checks++; if (o_empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
        checks++; if (o_full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
        checks++; if (o_count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        checks++; if (o_overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        i_wr_en = 1'b0;
        i_rst_n = 1'b1;
        begin
            int base = n_dv;
            repeat (20) tick();
            checks++; if (n_dv - base != 0) begin errors++; $display("FAIL reset_no_dv: got %0d pulses want 0", n_dv - base); end
        end
    endtask

    task automatic test_single_byte();
        int rb = rx_q.size();
        bit ok;
        i_wr_en = 1'b1; i_wr_data = 8'hA5;
        tick();
        i_wr_en = 1'b0;
        checks++; if (o_empty !== 1'b0)    begin errors++; $display("FAIL single_empty_k: got %b want 0", o_empty); end
        checks++; if (o_count !== 3'd1)    begin errors++; $display("FAIL single_count_k: got %0d want 1", o_count); end
        checks++; if (o_tx_dv !== 1'b0)    begin errors++; $display("FAIL single_dv_k: got %b want 0", o_tx_dv); end
        tick();
        checks++; if (o_tx_dv !== 1'b1)    begin errors++; $display("FAIL single_dv_k1: got %b want 1", o_tx_dv); end
        checks++; if (o_tx_byte !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h want a5", o_tx_byte); end
        checks++; if (o_count !== 3'd0)    begin errors++; $display("FAIL single_count_k1: got %0d want 0", o_count); end
        tick();
        checks++; if (o_tx_dv !== 1'b0)    begin errors++; $display("FAIL single_dv_k2: got %b want 0", o_tx_dv); end
        wait_rx(rb + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bytes want 1", rx_q.size() - rb); end
        else begin
            checks++; if (rx_q[rb] !== 8'hA5) begin errors++; $display("FAIL single_serial: got %h want a5", rx_q[rb]); end
        end
        wait_idle();
        checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin
            errors++; $display("FAIL single_drain: got empty=%b count=%0d want 1/0", o_empty, o_count);
        end
    endtask

    task automatic test_back_to_back();
        int   rb = rx_q.size();
        int   d0 = n_dv, g0 = n_gapv, l0 = n_long, u0 = n_unst;
        bit   ok;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            i_wr_en = 1'b1; i_wr_data = exp_b[i];
            tick();
        end
        i_wr_en = 1'b0;
        wait_rx(rb + 3, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d bytes want 3", rx_q.size() - rb); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[rb + i] !== exp_b[i]) begin
                    errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, rx_q[rb + i], exp_b[i]);
                end
            end
        end
        wait_idle();
        checks++; if (n_dv - d0 != 3)   begin errors++; $display("FAIL burst_dv_count: got %0d want 3", n_dv - d0); end
        checks++; if (n_gapv - g0 != 0) begin errors++; $display("FAIL burst_gap: got %0d violations want 0", n_gapv - g0); end
        checks++; if (n_long - l0 != 0) begin errors++; $display("FAIL burst_dv_width: got %0d long cycles want 0", n_long - l0); end
        checks++; if (n_unst - u0 != 0) begin errors++; $display("FAIL burst_byte_stable: got %0d changes want 0", n_unst - u0); end
    endtask

    task automatic test_overflow();
        int rb = rx_q.size();
        int o0 = n_ovf;
        bit ok;
        for (int i = 1; i <= 5; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'(i);
            tick();
        end
        checks++; if (o_full !== 1'b1 || o_count !== 3'd4) begin
            errors++; $display("FAIL ovf_full: got full=%b count=%0d want 1/4", o_full, o_count);
        end
        i_wr_data = 8'h06;
        tick();
        i_wr_en = 1'b0;
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", o_overflow); end
        checks++; if (o_count !== 3'd4)    begin errors++; $display("FAIL ovf_count_hold: got %0d want 4", o_count); end
        tick();
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b want 0", o_overflow); end
        wait_rx(rb + 5, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got %0d bytes want 5", rx_q.size() - rb); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_q[rb + i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, rx_q[rb + i], 8'(i + 1));
                end
            end
        end
        wait_idle();
        checks++; if (n_ovf - o0 != 1)      begin errors++; $display("FAIL ovf_once: got %0d pulses want 1", n_ovf - o0); end
        checks++; if (rx_q.size() != rb + 5) begin errors++; $display("FAIL ovf_dropped: got %0d bytes want 5", rx_q.size() - rb); end
    endtask

    task automatic test_simultaneous();
        int rb = rx_q.size();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'h61 + 8'(i);
            tick();
        end
        i_wr_en = 1'b0;
        checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL sim_count_pre: got %0d want 2", o_count); end
        for (int i = 0; i < 200 && !m_done; i++) tick();
        checks++; if (!m_done) begin errors++; $display("FAIL sim_done_timeout: got done=%b want 1", m_done); end
        tick();
        tick();
        i_wr_en = 1'b1; i_wr_data = 8'h64;
        tick();
        i_wr_en = 1'b0;
        checks++; if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h62) begin
            errors++; $display("FAIL sim_pop: got dv=%b byte=%h want 1/62", o_tx_dv, o_tx_byte);
        end
        checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL sim_count: got %0d want 2", o_count); end
        wait_rx(rb + 4, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sim_timeout: got %0d bytes want 4", rx_q.size() - rb); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rx_q[rb + i] !== 8'h61 + 8'(i)) begin
                    errors++; $display("FAIL sim_order[%0d]: got %h want %h", i, rx_q[rb + i], 8'h61 + 8'(i));
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        int rb = rx_q.size();
        int d0;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'h41 + 8'(i);
            tick();
        end
        i_wr_en = 1'b0;
        wait_rx(rb + 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_first_timeout: got %0d bytes want 1", rx_q.size() - rb); end
        for (int i = 0; i < 50 && !m_active; i++) tick();
        repeat (8) tick();
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00) begin
            errors++; $display("FAIL mid_rst_tx: got dv=%b byte=%h want 0/00", o_tx_dv, o_tx_byte);
        end
        checks++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
            errors++; $display("FAIL mid_rst_fifo: got count=%0d empty=%b full=%b want 0/1/0", o_count, o_empty, o_full);
        end
        tick();
        i_rst_n = 1'b1;
        d0 = n_dv;
        repeat (300) tick();
        checks++; if (n_dv - d0 != 0)        begin errors++; $display("FAIL mid_no_dv: got %0d pulses want 0", n_dv - d0); end
        checks++; if (rx_q.size() != rb + 1) begin errors++; $display("FAIL mid_no_tail: got %0d bytes want 1", rx_q.size() - rb); end
        i_wr_en = 1'b1; i_wr_data = 8'h5A;
        tick();
        i_wr_en = 1'b0;
        wait_rx(rb + 2, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_fresh_timeout: got %0d bytes want 2", rx_q.size() - rb); end
        else begin
            checks++; if (rx_q[rb + 1] !== 8'h5A) begin errors++; $display("FAIL mid_fresh: got %h want 5a", rx_q[rb + 1]); end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
